// File: rtl/mem_responder.sv
// Word memory responder with wait states, latched requests and error reporting.
// Optional `MEM_RESPONDER_BYTE_STROBE_EN enables per-byte write strobes.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt;
    logic            wr_q, err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH];

    logic            accept, req_err, load_rsp;
    logic            cur_err, cur_wr;
    logic [AW-1:0]   cur_idx;
    logic            do_write;

    assign accept  = (state == IDLE) && (mem_read || mem_write);
    assign req_err = (mem_read && mem_write) ||
                     (addr[1:0] != 2'b00) ||
                     ((addr >> (AW + 2)) != 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd0) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt     <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            wr_q    <= mem_write;
            err_q   <= req_err;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With zero wait states the response is loaded on the acceptance edge,
    // so the live request must be used instead of the latched copy.
    assign cur_err  = (state == IDLE) ? req_err : err_q;
    assign cur_wr   = (state == IDLE) ? mem_write : wr_q;
    assign cur_idx  = (state == IDLE) ? addr[AW+1:2] : idx_q;
    assign load_rsp = (state_n == RESP) && (state != RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (load_rsp) begin
            if (cur_err)     rdata <= '0;
            else if (!cur_wr) rdata <= mem[cur_idx];
        end
    end

    assign do_write = (state == RESP) && wr_q && !err_q && !reset;

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    logic [3:0] wstrb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       wstrb_q <= '0;
        else if (accept) wstrb_q <= wstrb;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^wstrb;

    always_ff @(posedge clk) begin
        if (do_write) mem[idx_q] <= wdata_q;
    end
`endif

    assign ready = (state == RESP);
    assign err   = ready && err_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder (WAIT_CYCLES=2 and 0).
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;

    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_strb, b_strb;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_err, a_busy, b_ready, b_err, b_busy;

    int checks = 0;
    int errors = 0;

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    localparam logic [31:0] EXP_STRB = 32'hAA22CC44;
    localparam logic [31:0] EXP_ZERO = 32'hAAAA0000;
`else
    localparam logic [31:0] EXP_STRB = 32'h11223344;
    localparam logic [31:0] EXP_ZERO = 32'hFFFFFFFF;
`endif

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(reset),
        .mem_read(a_rd), .mem_write(a_wr),
        .addr(a_addr), .wdata(a_wdata), .wstrb(a_strb),
        .rdata(a_rdata), .ready(a_ready), .err(a_err), .busy(a_busy)
    );

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset),
        .mem_read(b_rd), .mem_write(b_wr),
        .addr(b_addr), .wdata(b_wdata), .wstrb(b_strb),
        .rdata(b_rdata), .ready(b_ready), .err(b_err), .busy(b_busy)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (!sel) begin
            a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d; a_strb = s;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = a; b_wdata = d; b_strb = s;
        end
    endtask

    task automatic do_req(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat,
                          output logic [31:0] rdo, output logic ero);
        @(negedge clk);
        drive(sel, rd, wr, a, d, s);
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        lat = 0;
        rdo = 32'hx;
        ero = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                lat = n;
                rdo = sel ? b_rdata : a_rdata;
                ero = sel ? b_err : a_err;
                break;
            end
        end
    endtask

    vec_t tbl [19];
    int          lat;
    logic [31:0] rdo;
    logic        ero;
    int          extra;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h8, 32'h11223344, 4'h5, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h8, 32'h0, 4'h0, EXP_STRB, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h30, 32'hAAAA0000, 4'hF, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h30, 32'h0, 4'h0, EXP_ZERO, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'hFFC, 32'h01020304, 4'hF, 32'h0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, 32'h01020304, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 32'h14, 32'h77777777, 4'hF, 32'h0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 32'h16, 32'h55555555, 4'hF, 32'h0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h77777777, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 32'hFFFFFFF0, 32'h1, 4'hF, 32'h0, 1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_ready_a", 32'(a_ready), 32'd0);
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_err_a", 32'(a_err), 32'd0);
        chk("rst_rdata_a", a_rdata, 32'd0);
        chk("rst_busy_b", 32'(b_busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            do_req(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                   tbl[i].strb, lat, rdo, ero);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_err", i), 32'(ero), 32'(tbl[i].exp_err));
            if (tbl[i].rd)
                chk($sformatf("v%0d_rdata", i), rdo, tbl[i].exp_rdata);
        end

        // abort a write with reset while it sits in WAIT
        do_req(1'b0, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, lat, rdo, ero);
        do_req(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, rdo, ero);
        chk("pre_rst_rd", rdo, 32'h0BADF00D);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h4, 32'h99999999, 4'hF);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk("wait_busy", 32'(a_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(a_busy), 32'd0);
        chk("arst_ready", 32'(a_ready), 32'd0);
        chk("arst_rdata", a_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, rdo, ero);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_rd", rdo, 32'h0BADF00D);

        // zero wait states, small memory
        do_req(1'b1, 1'b0, 1'b1, 32'h0, 32'h11111111, 4'hF, lat, rdo, ero);
        chk("b_wr_lat", 32'(lat), 32'd1);
        do_req(1'b1, 1'b0, 1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, lat, rdo, ero);
        do_req(1'b1, 1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, lat, rdo, ero);
        chk("b_last_rd", rdo, 32'hA5A5A5A5);
        chk("b_last_err", 32'(ero), 32'd0);
        do_req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rdo, ero);
        chk("b_oob_lat", 32'(lat), 32'd1);
        chk("b_oob_err", 32'(ero), 32'd1);
        chk("b_oob_rd", rdo, 32'd0);

        // second request held while busy must be ignored
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h22222222, 4'hF);
        @(posedge clk);
        #1 b_wdata = 32'h33333333;
        @(negedge clk);
        chk("b_busy_ready", 32'(b_ready), 32'd1);
        chk("b_busy_busy", 32'(b_busy), 32'd1);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (b_ready) extra++;
        end
        chk("b_ignored_resp", 32'(extra), 32'd0);
        do_req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rdo, ero);
        chk("b_ignored_data", rdo, 32'h22222222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
